// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage buffer (pipe_stage_buf).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef logic [1:0] occ_t;

  localparam int STALL_W_DEF   = 6;
  localparam int PAYLOAD_W_MAX = 1024;
  localparam logic [PAYLOAD_W_MAX-1:0] ZERO_PAYLOAD = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register with clear (priority) and load; used for the main and skid entries.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int W = 76
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_data;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_data <= ZERO_PAYLOAD[W-1:0];
    end else if (i_clear) begin
      r_data <= ZERO_PAYLOAD[W-1:0];
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer with stall, flush, global enable and bubble counter.
// Macro PIPE_SKID_EN adds the skid entry and a registered in_ready; undefined gives one entry.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 76,
  parameter int STALL_W   = STALL_W_DEF,
  parameter int STAGE_IDX = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [STALL_W-1:0]   stall_in,
  input  logic                 flush_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output occ_t                 occupancy,
  output logic [CNT_W-1:0]     bubble_cnt
);

`ifdef PIPE_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_in_en;
  logic [CNT_W-1:0]     r_bubble_cnt;
  logic                 w_hold_up;
  logic                 w_hold_dn;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_bubble;
  logic                 w_main_load;
  logic                 w_main_clear;
  logic                 w_skid_load;
  logic                 w_skid_clear;
  logic [PAYLOAD_W-1:0] w_main_din;
  logic [PAYLOAD_W-1:0] w_main_q;
  logic [PAYLOAD_W-1:0] w_skid_q;
  logic                 w_unused_stall;

  assign w_hold_up      = stall_in[STAGE_IDX];
  assign w_hold_dn      = stall_in[STAGE_IDX+1];
  assign w_unused_stall = ^stall_in;

  assign out_valid  = (r_state != EMPTY);
  assign out_data   = w_main_q;
  assign w_in_fire  = in_valid & in_ready & rdy_in & ~w_hold_up & ~flush_in;
  assign w_out_fire = out_valid & out_ready & rdy_in & ~w_hold_dn & ~flush_in;
  assign w_bubble   = rdy_in & ~w_hold_dn & out_ready & ~out_valid;

  always_comb begin
    w_state_next = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    w_main_din   = in_data;
    if (rdy_in) begin
      if (flush_in) begin
        w_state_next = EMPTY;
        w_main_clear = 1'b1;
        w_skid_clear = 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_in_fire) begin
              w_state_next = ONE;
              w_main_load  = 1'b1;
            end
          end
          ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_main_load = 1'b1;
            end else if (w_out_fire) begin
              w_state_next = EMPTY;
              w_main_clear = 1'b1;
            end else if (w_in_fire && SKID_EN) begin
              w_state_next = TWO;
              w_skid_load  = 1'b1;
            end
          end
          TWO: begin
            // Skid always drains into main so ordering stays FIFO.
            if (w_out_fire) begin
              w_state_next = ONE;
              w_main_din   = w_skid_q;
              w_main_load  = 1'b1;
              w_skid_clear = 1'b1;
            end
          end
          default: begin
            w_state_next = EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= EMPTY;
      r_bubble_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  pipe_skid_slot #(.W(PAYLOAD_W)) u_main (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_data  (w_main_q)
  );

`ifdef PIPE_SKID_EN
  pipe_skid_slot #(.W(PAYLOAD_W)) u_skid (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .o_data  (w_skid_q)
  );

  // Registered "not full" flag keeps out_ready off the in_ready path.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_in_en <= 1'b0;
    end else begin
      r_in_en <= (w_state_next != TWO);
    end
  end

  assign in_ready = r_in_en & rdy_in;
`else
  logic w_unused_skid;

  assign w_skid_q      = '0;
  assign w_unused_skid = w_skid_load | w_skid_clear;

  // Here r_in_en only marks that reset has been released.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_in_en <= 1'b0;
    end else begin
      r_in_en <= 1'b1;
    end
  end

  assign in_ready = r_in_en & rdy_in & ((r_state == EMPTY) | w_out_fire);
`endif

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf; builds with or without PIPE_SKID_EN.
module tb_pipe_stage_buf;

  localparam int PW = 76;
  localparam int SW = 6;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic [SW-1:0] stall_in;
  logic          flush_in;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] bubble_cnt;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_bub = '0;
  logic [PW-1:0] d [0:9];

  pipe_stage_buf #(.PAYLOAD_W(PW), .STALL_W(SW), .STAGE_IDX(3), .CNT_W(CW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; stall_in = '0; flush_in = 1'b0;
    in_valid = 1'b1; in_data = PW'(8'h5A); out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (bubble_cnt !== '0) begin n_fail++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    rst_in = 1'b0;
    tick();
    exp_bub = exp_bub + 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_no_fire: got %0b want 0", out_valid); end
    in_valid = 1'b0; out_ready = 1'b0;
    $display("reset: done, bubble_cnt=%0d", bubble_cnt);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = d[i];
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, d[i]); end
      n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL b2b_occ[%0d]: got %0d want 1", i, occupancy); end
      $display("b2b: D%0d out=%h", i, out_data);
    end
    in_valid = 1'b0;
    tick();
    exp_bub = exp_bub + 1'b1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL b2b_drain: got v=%0b d=%h want v=0 d=0", out_valid, out_data); end
    n_cmp++; if (bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL b2b_bubble: got %0d want %0d", bubble_cnt, exp_bub); end
    out_ready = 1'b0;
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = d[0];
    tick();
`ifdef PIPE_SKID_EN
    in_data = d[1];
    tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_occ_full: got %0d want 2", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready: got %0b want 0", in_ready); end
    in_data = d[2];
    tick();
    n_cmp++; if (occupancy !== 2'd2 || out_data !== d[0]) begin n_fail++; $display("FAIL skid_hold: got occ=%0d d=%h want occ=2 d=%h", occupancy, out_data, d[0]); end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== d[i]) begin n_fail++; $display("FAIL skid_order[%0d]: got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, d[i]); end
      $display("skid: D%0d out=%h occ=%0d", i, out_data, occupancy);
    end
`else
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL one_in_ready: got %0b want 0", in_ready); end
    in_data = d[1];
    tick();
    n_cmp++; if (occupancy !== 2'd1 || out_data !== d[0]) begin n_fail++; $display("FAIL one_hold: got occ=%0d d=%h want occ=1 d=%h", occupancy, out_data, d[0]); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL one_in_ready_swap: got %0b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== d[1]) begin n_fail++; $display("FAIL one_swap: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, d[1]); end
    $display("one: D1 out=%h occ=%0d", out_data, occupancy);
`endif
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_drain: got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    stall_in = 6'b001000; in_valid = 1'b1; in_data = d[4]; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble[%0d]: got %0b want 0", i, out_valid); end
    end
    exp_bub = exp_bub + 3'd3;
    n_cmp++; if (bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", bubble_cnt, exp_bub); end
    stall_in = '0;
    tick();
    exp_bub = exp_bub + 1'b1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== d[4]) begin n_fail++; $display("FAIL stall_release: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, d[4]); end
    $display("stall: upstream hold, bubble_cnt=%0d", bubble_cnt);
    in_valid = 1'b0; stall_in = 6'b010000;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== d[4]) begin n_fail++; $display("FAIL stall_dn_hold: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, d[4]); end
    n_cmp++; if (bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL stall_dn_count: got %0d want %0d", bubble_cnt, exp_bub); end
    stall_in = '0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dn_release: got %0b want 0", out_valid); end
    $display("stall: downstream hold, bubble_cnt=%0d", bubble_cnt);
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = d[6];
    tick();
`ifdef PIPE_SKID_EN
    in_data = d[7];
    tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
`else
    n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 1", occupancy); end
`endif
    flush_in = 1'b1; in_data = d[8];
    tick();
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin n_fail++; $display("FAIL flush_clear: got v=%0b occ=%0d d=%h want 0/0/0", out_valid, occupancy, out_data); end
    flush_in = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %0b want 0", out_valid); end
    $display("flush: occ=%0d out_valid=%0b", occupancy, out_valid);
  endtask

  task automatic test_rdy();
    out_ready = 1'b0; in_valid = 1'b1; in_data = d[5];
    tick();
    in_valid = 1'b0; rdy_in = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== d[5] || occupancy !== 2'd1) begin n_fail++; $display("FAIL rdy_freeze[%0d]: got v=%0b d=%h occ=%0d want v=1 d=%h occ=1", i, out_valid, out_data, occupancy, d[5]); end
      n_cmp++; if (bubble_cnt !== exp_bub || in_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_freeze_cnt[%0d]: got cnt=%0d rdy=%0b want cnt=%0d rdy=0", i, bubble_cnt, in_ready, exp_bub); end
    end
    rdy_in = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL rdy_resume: got v=%0b d=%h want v=0 d=0", out_valid, out_data); end
    $display("rdy: frozen 4 cycles then transferred, bubble_cnt=%0d", bubble_cnt);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = d[9];
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== d[9]) begin n_fail++; $display("FAIL arst_load: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, d[9]); end
    #2 rst_in = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL arst_clear: got v=%0b d=%h occ=%0d want 0/0/0", out_valid, out_data, occupancy); end
    n_cmp++; if (bubble_cnt !== '0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_cnt: got cnt=%0d rdy=%0b want 0/0", bubble_cnt, in_ready); end
    tick();
    rst_in = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release: got %0b want 1", in_ready); end
    $display("async reset: cleared mid-cycle");
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      d[i] = {4'(i), 8'hC3, 64'hDEAD_BEEF_0000_0000 + 64'(i) * 64'h1111_0101};
    end
    test_reset();
    test_back_to_back();
    test_skid();
    test_stall();
    test_rdy();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
